// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin FIFO arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StStall = 2'b10
    } arb_state_e;

    localparam int unsigned DefaultNIn  = 4;
    localparam int unsigned DefaultBurst = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Circular first-one finder: scans req_i from start_i upward, wrapping at N.
module rr_select #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] start_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned k;
        logic [IdxW-1:0] kw;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        kw      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k  = (32'(start_i) + i) % N;
            kw = IdxW'(k);
            if (!valid_o && req_i[kw]) begin
                valid_o   = 1'b1;
                gnt_o[kw] = 1'b1;
                idx_o     = kw;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter draining N_IN upstream FIFOs into one downstream FIFO,
// with per-queue burst limit and downstream back-pressure.
module fifo_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 12,
    parameter int unsigned N_IN      = DefaultNIn,
    parameter int unsigned BURST     = DefaultBurst
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_IN-1:0]                   in_empty_i,
    input  logic [N_IN*WORD_SIZE-1:0]         in_data_i,
    input  logic                              ds_almost_full_i,
    input  logic                              ds_full_i,
    output logic [N_IN-1:0]                   pop_o,
    output logic                              push_o,
    output logic [WORD_SIZE-1:0]              data_out_o,
    output logic [arb_pkg::clog2(N_IN)-1:0]   cur_q_o,
    output logic                              error_o
);

    localparam int unsigned QW = clog2(N_IN);
    localparam int unsigned BW = clog2(BURST + 1);

    arb_state_e           state_q, state_d;
    logic [QW-1:0]        cur_q_q, cur_q_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic                 push_q, push_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 error_q, error_d;

    logic [N_IN-1:0] req;
    logic            go;
    logic            keep;
    logic [QW-1:0]   start_idx;
    logic [N_IN-1:0] rr_gnt;
    logic [QW-1:0]   rr_idx;
    logic            rr_valid;
    logic [QW-1:0]   sel_idx;

    assign req = ~in_empty_i;

    // Reset gates pop so nothing is requested upstream while held in reset.
    assign go = rst_ni & (state_q != StStall) & ~ds_almost_full_i & ~ds_full_i & (|req);

    assign start_idx = (cur_q_q == QW'(N_IN - 1)) ? '0 : cur_q_q + QW'(1);
    assign keep      = req[cur_q_q] & (32'(burst_cnt_q) < BURST);

    rr_select #(
        .N    (N_IN),
        .IdxW (QW)
    ) u_rr_select (
        .req_i   (req),
        .start_i (start_idx),
        .gnt_o   (rr_gnt),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    // The scan wraps back to cur_q last, so a lone non-empty queue restarts its burst.
    assign sel_idx = (keep || !rr_valid) ? cur_q_q : rr_idx;

    always_comb begin
        pop_o = '0;
        if (go) begin
            if (keep || !rr_valid) begin
                pop_o[cur_q_q] = 1'b1;
            end else begin
                pop_o = rr_gnt;
            end
        end
    end

    always_comb begin
        state_d     = StIdle;
        cur_q_d     = cur_q_q;
        burst_cnt_d = burst_cnt_q;
        push_d      = 1'b0;
        data_d      = data_q;
        error_d     = error_q | (push_q & ds_full_i);

        if (ds_almost_full_i || ds_full_i) begin
            state_d = StStall;
        end else if (|req) begin
            state_d = StRun;
        end

        if (go) begin
            push_d = 1'b1;
            data_d = in_data_i[32'(sel_idx) * WORD_SIZE +: WORD_SIZE];
            if (keep) begin
                burst_cnt_d = burst_cnt_q + BW'(1);
            end else begin
                cur_q_d     = sel_idx;
                burst_cnt_d = BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cur_q_q     <= '0;
            burst_cnt_q <= '0;
            push_q      <= 1'b0;
            data_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q_q     <= cur_q_d;
            burst_cnt_q <= burst_cnt_d;
            push_q      <= push_d;
            data_q      <= data_d;
            error_q     <= error_d;
        end
    end

    assign push_o     = push_q;
    assign data_out_o = data_q;
    assign cur_q_o    = cur_q_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: reset, round-robin order, empty skipping,
// back-pressure and sticky overflow, with hand-computed expectations.
module tb_fifo_arbiter;

    localparam int unsigned WS = 12;
    localparam int unsigned N  = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  in_empty;
    logic [N*WS-1:0] in_data;
    logic          ds_af;
    logic          ds_full;
    logic [N-1:0]  pop;
    logic          push;
    logic [WS-1:0] data_out;
    logic [1:0]    cur_q;
    logic          error;

    int n_vec;
    int n_err;

    fifo_arbiter #(
        .WORD_SIZE (WS),
        .N_IN      (N),
        .BURST     (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .in_empty_i       (in_empty),
        .in_data_i        (in_data),
        .ds_almost_full_i (ds_af),
        .ds_full_i        (ds_full),
        .pop_o            (pop),
        .push_o           (push),
        .data_out_o       (data_out),
        .cur_q_o          (cur_q),
        .error_o          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check the outputs.
    task automatic cyc(input string tag, input logic [3:0] emp, input logic af,
                       input logic full, input logic [3:0] exp_pop,
                       input logic exp_push, input logic [11:0] exp_data);
        @(negedge clk);
        in_empty = emp;
        ds_af    = af;
        ds_full  = full;
        #1;
        check_eq({tag, ".pop"}, 32'(pop), 32'(exp_pop));
        check_eq({tag, ".push"}, 32'(push), 32'(exp_push));
        check_eq({tag, ".data"}, 32'(data_out), 32'(exp_data));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_empty = 4'b1111;
        ds_af    = 1'b0;
        ds_full  = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_empty = 4'b1111;
        ds_af    = 1'b0;
        ds_full  = 1'b0;
        in_data  = {12'h0D3, 12'h0C2, 12'h0B1, 12'h0A0};
        #2;
        check_eq("rst.pop", 32'(pop), 0);
        check_eq("rst.push", 32'(push), 0);
        check_eq("rst.data", 32'(data_out), 0);
        check_eq("rst.cur_q", 32'(cur_q), 0);
        check_eq("rst.error", 32'(error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle0", 4'b1111, 0, 0, 4'b0000, 0, 12'h000);

        // Round robin, all queues occupied.
        cyc("rr1",  4'b0000, 0, 0, 4'b0001, 0, 12'h000);
        cyc("rr2",  4'b0000, 0, 0, 4'b0001, 1, 12'h0A0);
        cyc("rr3",  4'b0000, 0, 0, 4'b0010, 1, 12'h0A0);
        cyc("rr4",  4'b0000, 0, 0, 4'b0010, 1, 12'h0B1);
        cyc("rr5",  4'b0000, 0, 0, 4'b0100, 1, 12'h0B1);
        cyc("rr6",  4'b0000, 0, 0, 4'b0100, 1, 12'h0C2);
        cyc("rr7",  4'b0000, 0, 0, 4'b1000, 1, 12'h0C2);
        cyc("rr8",  4'b0000, 0, 0, 4'b1000, 1, 12'h0D3);
        cyc("rr9",  4'b0000, 0, 0, 4'b0001, 1, 12'h0D3);
        cyc("rr10", 4'b0000, 0, 0, 4'b0001, 1, 12'h0A0);
        check_eq("rr10.cur_q", 32'(cur_q), 0);

        // Asynchronous reset with a push in flight.
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst.push", 32'(push), 0);
        check_eq("arst.data", 32'(data_out), 0);
        check_eq("arst.pop", 32'(pop), 0);
        check_eq("arst.cur_q", 32'(cur_q), 0);
        in_empty = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle1", 4'b1111, 0, 0, 4'b0000, 0, 12'h000);
        cyc("idle2", 4'b1111, 0, 0, 4'b0000, 0, 12'h000);

        // Only q1 and q3 occupied.
        cyc("skip1", 4'b0101, 0, 0, 4'b0010, 0, 12'h000);
        cyc("skip2", 4'b0101, 0, 0, 4'b0010, 1, 12'h0B1);
        cyc("skip3", 4'b0101, 0, 0, 4'b1000, 1, 12'h0B1);
        cyc("skip4", 4'b0101, 0, 0, 4'b1000, 1, 12'h0D3);
        cyc("skip5", 4'b0101, 0, 0, 4'b0010, 1, 12'h0D3);

        // Only q2 occupied: popped every cycle, burst restarts.
        cyc("solo1", 4'b1011, 0, 0, 4'b0100, 1, 12'h0B1);
        cyc("solo2", 4'b1011, 0, 0, 4'b0100, 1, 12'h0C2);
        cyc("solo3", 4'b1011, 0, 0, 4'b0100, 1, 12'h0C2);
        cyc("solo4", 4'b1011, 0, 0, 4'b0100, 1, 12'h0C2);
        check_eq("solo.cur_q", 32'(cur_q), 2);

        // Back-pressure after the third pop.
        do_reset();
        cyc("bp1", 4'b0000, 0, 0, 4'b0001, 0, 12'h000);
        cyc("bp2", 4'b0000, 0, 0, 4'b0001, 1, 12'h0A0);
        cyc("bp3", 4'b0000, 0, 0, 4'b0010, 1, 12'h0A0);
        cyc("bp4", 4'b0000, 1, 0, 4'b0000, 1, 12'h0B1);
        cyc("bp5", 4'b0000, 1, 0, 4'b0000, 0, 12'h0B1);
        cyc("bp6", 4'b0000, 0, 0, 4'b0000, 0, 12'h0B1);
        cyc("bp7", 4'b0000, 0, 0, 4'b0010, 0, 12'h0B1);
        check_eq("bp7.error", 32'(error), 0);

        // Overflow: ds_full high while the q1 word is pushed.
        cyc("ovf1", 4'b0000, 0, 1, 4'b0000, 1, 12'h0B1);
        cyc("ovf2", 4'b0000, 0, 0, 4'b0000, 0, 12'h0B1);
        check_eq("ovf2.error", 32'(error), 1);
        cyc("ovf3", 4'b0000, 0, 0, 4'b0100, 0, 12'h0B1);
        cyc("ovf4", 4'b0000, 0, 0, 4'b0100, 1, 12'h0C2);
        check_eq("ovf4.error", 32'(error), 1);
        do_reset();
        #1;
        check_eq("ovf.clr", 32'(error), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
